// File: rtl/rob_param_if.sv
// rob_param_if: issue, writeback, operand-lookup and commit bundle for rob_param.
interface rob_param_if #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int DATA_W = 32
);
    logic              rdy_in;
    logic              flush_in;
    logic              alloc_en_in;
    logic [4:0]        alloc_rd_in;
    logic [DATA_W-1:0] alloc_pc_in;
    logic              alloc_bp_in;
    logic [IDX_W-1:0]  alloc_idx_out;
    logic              full_out;
    logic              empty_out;
    logic [IDX_W:0]    count_out;
    logic              wb0_en_in;
    logic [IDX_W-1:0]  wb0_idx_in;
    logic [DATA_W-1:0] wb0_res_in;
    logic              wb0_jump_en_in;
    logic [DATA_W-1:0] wb0_jump_a_in;
    logic              wb1_en_in;
    logic [IDX_W-1:0]  wb1_idx_in;
    logic [DATA_W-1:0] wb1_res_in;
    logic [IDX_W-1:0]  rs1_idx_in;
    logic [IDX_W-1:0]  rs2_idx_in;
    logic              rs1_ready_out;
    logic              rs2_ready_out;
    logic [DATA_W-1:0] rs1_res_out;
    logic [DATA_W-1:0] rs2_res_out;
    logic              commit_en_out;
    logic [IDX_W-1:0]  commit_idx_out;
    logic [4:0]        commit_rd_out;
    logic [DATA_W-1:0] commit_res_out;
    logic [DATA_W-1:0] commit_pc_out;
    logic [DATA_W-1:0] commit_jump_a_out;
    logic              commit_jump_en_out;
    logic              commit_bp_out;

    modport master (
        output rdy_in, flush_in, alloc_en_in, alloc_rd_in, alloc_pc_in, alloc_bp_in,
               wb0_en_in, wb0_idx_in, wb0_res_in, wb0_jump_en_in, wb0_jump_a_in,
               wb1_en_in, wb1_idx_in, wb1_res_in, rs1_idx_in, rs2_idx_in,
        input  alloc_idx_out, full_out, empty_out, count_out,
               rs1_ready_out, rs2_ready_out, rs1_res_out, rs2_res_out,
               commit_en_out, commit_idx_out, commit_rd_out, commit_res_out, commit_pc_out,
               commit_jump_a_out, commit_jump_en_out, commit_bp_out
    );

    modport slave (
        input  rdy_in, flush_in, alloc_en_in, alloc_rd_in, alloc_pc_in, alloc_bp_in,
               wb0_en_in, wb0_idx_in, wb0_res_in, wb0_jump_en_in, wb0_jump_a_in,
               wb1_en_in, wb1_idx_in, wb1_res_in, rs1_idx_in, rs2_idx_in,
        output alloc_idx_out, full_out, empty_out, count_out,
               rs1_ready_out, rs2_ready_out, rs1_res_out, rs2_res_out,
               commit_en_out, commit_idx_out, commit_rd_out, commit_res_out, commit_pc_out,
               commit_jump_a_out, commit_jump_en_out, commit_bp_out
    );
endinterface

// File: rtl/rob_param.sv
// rob_param: circular reorder buffer with two writeback ports, operand forwarding
// and in-order single-entry commit.
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input logic        clk_in,
    input logic        rst_n_in,
    rob_param_if.slave bus
);
    logic [IDX_W-1:0]  head, tail;
    logic [IDX_W:0]    count;
    logic [DEPTH-1:0]  valid, done, valid_nxt, done_nxt;
    logic [4:0]        rd_q    [DEPTH];
    logic [DATA_W-1:0] pc_q    [DEPTH];
    logic              bp_q    [DEPTH];
    logic [DATA_W-1:0] res_q   [DEPTH];
    logic              jen_q   [DEPTH];
    logic [DATA_W-1:0] ja_q    [DEPTH];
    logic              c_en, c_jen, c_bp;
    logic [IDX_W-1:0]  c_idx;
    logic [4:0]        c_rd;
    logic [DATA_W-1:0] c_res, c_pc, c_ja;
    logic full, alloc_ok, commit_ok, wb0_hit, wb1_hit, upd;
    logic f01, f11, f02, f12;

    assign full      = count == (IDX_W+1)'(DEPTH);
    assign alloc_ok  = bus.alloc_en_in && !full;
    assign commit_ok = valid[head] && done[head];
    assign wb0_hit   = bus.wb0_en_in && valid[bus.wb0_idx_in];
    assign wb1_hit   = bus.wb1_en_in && valid[bus.wb1_idx_in];
    assign upd       = rst_n_in && bus.rdy_in && !bus.flush_in;

    // Later assignments win, so a same-index wb0 overrides wb1 and alloc overrides commit.
    always_comb begin
        valid_nxt = valid;
        done_nxt  = done;
        if (wb1_hit) done_nxt[bus.wb1_idx_in] = 1'b1;
        if (wb0_hit) done_nxt[bus.wb0_idx_in] = 1'b1;
        if (commit_ok) begin
            valid_nxt[head] = 1'b0;
            done_nxt[head]  = 1'b0;
        end
        if (alloc_ok) begin
            valid_nxt[tail] = 1'b1;
            done_nxt[tail]  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
            c_en  <= 1'b0;
            c_idx <= '0;
            c_rd  <= '0;
            c_res <= '0;
            c_pc  <= '0;
            c_ja  <= '0;
            c_jen <= 1'b0;
            c_bp  <= 1'b0;
        end else if (!bus.rdy_in) begin
            c_en <= 1'b0;
        end else if (bus.flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
            c_en  <= 1'b0;
        end else begin
            valid <= valid_nxt;
            done  <= done_nxt;
            count <= count + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(commit_ok);
            c_en  <= commit_ok;
            if (alloc_ok) tail <= tail + IDX_W'(1);
            if (commit_ok) begin
                head  <= head + IDX_W'(1);
                c_idx <= head;
                c_rd  <= rd_q[head];
                c_res <= res_q[head];
                c_pc  <= pc_q[head];
                c_ja  <= ja_q[head];
                c_jen <= jen_q[head];
                c_bp  <= bp_q[head];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (upd) begin
            if (alloc_ok) begin
                rd_q[tail] <= bus.alloc_rd_in;
                pc_q[tail] <= bus.alloc_pc_in;
                bp_q[tail] <= bus.alloc_bp_in;
            end
            if (wb1_hit) begin
                res_q[bus.wb1_idx_in] <= bus.wb1_res_in;
                jen_q[bus.wb1_idx_in] <= 1'b0;
            end
            if (wb0_hit) begin
                res_q[bus.wb0_idx_in] <= bus.wb0_res_in;
                jen_q[bus.wb0_idx_in] <= bus.wb0_jump_en_in;
                ja_q[bus.wb0_idx_in]  <= bus.wb0_jump_a_in;
            end
        end
    end

    assign f01 = wb0_hit && bus.wb0_idx_in == bus.rs1_idx_in;
    assign f11 = wb1_hit && bus.wb1_idx_in == bus.rs1_idx_in;
    assign f02 = wb0_hit && bus.wb0_idx_in == bus.rs2_idx_in;
    assign f12 = wb1_hit && bus.wb1_idx_in == bus.rs2_idx_in;

    assign bus.rs1_ready_out = done[bus.rs1_idx_in] || f01 || f11;
    assign bus.rs2_ready_out = done[bus.rs2_idx_in] || f02 || f12;
    assign bus.rs1_res_out   = f01 ? bus.wb0_res_in : f11 ? bus.wb1_res_in : res_q[bus.rs1_idx_in];
    assign bus.rs2_res_out   = f02 ? bus.wb0_res_in : f12 ? bus.wb1_res_in : res_q[bus.rs2_idx_in];

    assign bus.alloc_idx_out      = tail;
    assign bus.full_out           = full;
    assign bus.empty_out          = count == '0;
    assign bus.count_out          = count;
    assign bus.commit_en_out      = c_en;
    assign bus.commit_idx_out     = c_idx;
    assign bus.commit_rd_out      = c_rd;
    assign bus.commit_res_out     = c_res;
    assign bus.commit_pc_out      = c_pc;
    assign bus.commit_jump_a_out  = c_ja;
    assign bus.commit_jump_en_out = c_jen;
    assign bus.commit_bp_out      = c_bp;
endmodule
